// File: rtl/lsq_pkg.sv
// Shared definitions for the Merlin load/store queue.
// Holds RISC-V load/store funct3 encodings, the issue FSM state encoding and
// the register-width derivation used to size the data path.
package lsq_pkg;

   // Load/store width encodings (funct3). Stores use the B/H/W/D subset.
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RSP  = 2'd2
   } lsq_state_e;

   // Register width in bits from its log2 (5 -> 32, 6 -> 64).
   function automatic int unsigned xlen_of(input int unsigned xlen_x);
      return 32'd1 << xlen_x;
   endfunction

   // Queue entry: {is_store, funct3, regd_addr, hpl, addr, data}.
   function automatic int unsigned entry_w(input int unsigned xlen_x);
      return 1 + 3 + 5 + 2 + 2 * xlen_of(xlen_x);
   endfunction

endpackage

// File: rtl/lsq_fifo.sv
// Generic synchronous FIFO, 2**C_DEPTH_X entries of C_WIDTH bits.
// Latency: a pushed word is visible on data_o the cycle after the push.
// Backpressure: push while full and pop while empty are ignored.
// Ports: clk_i/reset_i (sync, active-high), push_i/data_i write side,
//        pop_i/data_o read side (data_o shows the head), full_o/empty_o flags.
module lsq_fifo #(
   parameter int unsigned C_WIDTH   = 8,
   parameter int unsigned C_DEPTH_X = 2
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               push_i,
   input  logic [C_WIDTH-1:0] data_i,
   input  logic               pop_i,
   output logic [C_WIDTH-1:0] data_o,
   output logic               full_o,
   output logic               empty_o
);

   localparam int unsigned C_DEPTH = 1 << C_DEPTH_X;
   localparam logic [C_DEPTH_X:0] C_FULL_CNT = C_DEPTH[C_DEPTH_X:0];

   logic [C_WIDTH-1:0]   mem_q [C_DEPTH];
   logic [C_DEPTH_X-1:0] wptr_q;
   logic [C_DEPTH_X-1:0] rptr_q;
   logic [C_DEPTH_X:0]   count_q;
   logic                 do_push;
   logic                 do_pop;

   // Flags come only from the registered count, so a pop does not open a
   // slot for a push until the following cycle.
   assign full_o  = (count_q == C_FULL_CNT);
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign data_o  = mem_q[rptr_q];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: it is only read when count_q says it is valid.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= data_i;
   end

endmodule

// File: rtl/lsq.sv
// Load/store queue: buffers memory ops in order and issues them one at a time.
// Latency: enqueue in cycle N -> dreqvalid_o in N+2; writeback/error pulse the
//          cycle after the accepted response. Backpressure: exs_full_o from the
//          registered count; dreqready_i/drspvalid_i stall the issue FSM.
// Ports: exs_* enqueue side, dreq*/drsp* data port, ids_reg_* load writeback,
//        hvec_* access-fault pulses, clk_en_i freezes all non-reset state.
module lsq
   import lsq_pkg::*;
#(
   parameter  int unsigned C_XLEN_X  = 5,
   parameter  int unsigned C_DEPTH_X = 2,
   localparam int unsigned C_XLEN    = xlen_of(C_XLEN_X),
   localparam int unsigned C_BYTES   = C_XLEN / 8
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               clk_en_i,
   input  logic               exs_lq_wr_i,
   input  logic               exs_sq_wr_i,
   input  logic [2:0]         exs_funct3_i,
   input  logic [4:0]         exs_regd_addr_i,
   input  logic [C_XLEN-1:0]  exs_regs2_data_i,
   input  logic [C_XLEN-1:0]  exs_addr_i,
   input  logic [1:0]         exs_hpl_i,
   output logic               exs_full_o,
   input  logic               dreqready_i,
   output logic               dreqvalid_o,
   output logic [1:0]         dreqhpl_o,
   output logic [C_XLEN-1:0]  dreqaddr_o,
   output logic               dreqwr_o,
   output logic [C_BYTES-1:0] dreqwben_o,
   output logic [C_XLEN-1:0]  dreqwdata_o,
   output logic               drspready_o,
   input  logic               drspvalid_i,
   input  logic               drsprerr_i,
   input  logic               drspwerr_i,
   input  logic [C_XLEN-1:0]  drspdata_i,
   output logic               ids_reg_wr_o,
   output logic [4:0]         ids_reg_addr_o,
   output logic [C_XLEN-1:0]  ids_reg_data_o,
   output logic               hvec_lerr_o,
   output logic               hvec_serr_o,
   output logic [C_XLEN-1:0]  hvec_err_addr_o
);

   localparam int unsigned C_ENTRY_W = entry_w(C_XLEN_X);

   // ---------------------------------------------------------------- queue
   logic [C_ENTRY_W-1:0] fifo_din;
   logic [C_ENTRY_W-1:0] fifo_dout;
   logic                 fifo_push;
   logic                 fifo_pop;
   logic                 fifo_full;
   logic                 fifo_empty;

   logic                 hd_store;
   logic [2:0]           hd_f3;
   logic [4:0]           hd_rd;
   logic [1:0]           hd_hpl;
   logic [C_XLEN-1:0]    hd_addr;
   logic [C_XLEN-1:0]    hd_data;
   logic [C_XLEN_X-4:0]  hd_off;

   lsq_state_e           state_q;

   assign fifo_din  = {exs_sq_wr_i, exs_funct3_i, exs_regd_addr_i, exs_hpl_i,
                       exs_addr_i, exs_regs2_data_i};
   assign fifo_push = (exs_lq_wr_i | exs_sq_wr_i) & clk_en_i;
   // The head is popped in the same cycle it is captured into issue registers.
   assign fifo_pop  = clk_en_i & (state_q == S_IDLE) & ~fifo_empty;
   assign {hd_store, hd_f3, hd_rd, hd_hpl, hd_addr, hd_data} = fifo_dout;
   assign hd_off    = hd_addr[C_XLEN_X-4:0];
   assign exs_full_o = fifo_full;

   lsq_fifo #(
      .C_WIDTH   (C_ENTRY_W),
      .C_DEPTH_X (C_DEPTH_X)
   ) u_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .push_i  (fifo_push),
      .data_i  (fifo_din),
      .pop_i   (fifo_pop),
      .data_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // ------------------------------------------------ store lane steering
   logic [C_BYTES-1:0] ben_base;
   logic [C_BYTES-1:0] st_wben;
   logic [C_XLEN-1:0]  st_wdata;

   always_comb begin
      ben_base = '0;
      st_wdata = '0;
      if (hd_store) begin
         case (hd_f3)
            F3_B: begin
               ben_base[0] = 1'b1;
               st_wdata    = {C_BYTES{hd_data[7:0]}};
            end
            F3_H: begin
               ben_base[1:0] = 2'b11;
               st_wdata      = {(C_BYTES/2){hd_data[15:0]}};
            end
            F3_W: begin
               ben_base[3:0] = 4'hF;
               st_wdata      = {(C_BYTES/4){hd_data[31:0]}};
            end
            default: begin
               ben_base = '1;
               st_wdata = hd_data;
            end
         endcase
      end
      // Loads keep ben_base at zero, so no lanes are enabled.
      st_wben = ben_base << hd_off;
   end

   // ---------------------------------------------------- issue registers
   logic               store_q;
   logic [2:0]         funct3_q;
   logic [4:0]         regd_q;
   logic [1:0]         hpl_q;
   logic [C_XLEN-1:0]  addr_q;
   logic [C_BYTES-1:0] wben_q;
   logic [C_XLEN-1:0]  wdata_q;
   logic               dreqvalid_q;
   logic               drspready_q;
   logic               reg_wr_q;
   logic [4:0]         reg_addr_q;
   logic [C_XLEN-1:0]  reg_data_q;
   logic               lerr_q;
   logic               serr_q;
   logic [C_XLEN-1:0]  err_addr_q;

   // ------------------------------------------------- load data steering
   logic [C_XLEN_X-4:0] off_q;
   logic [C_XLEN-1:0]   ld_sh;
   logic [C_XLEN-1:0]   ld_val;

   assign off_q = addr_q[C_XLEN_X-4:0];

   always_comb begin
      ld_sh  = drspdata_i >> {off_q, 3'b000};
      ld_val = ld_sh;
      case (funct3_q)
         F3_B: begin
            ld_val      = {C_XLEN{ld_sh[7]}};
            ld_val[7:0] = ld_sh[7:0];
         end
         F3_H: begin
            ld_val       = {C_XLEN{ld_sh[15]}};
            ld_val[15:0] = ld_sh[15:0];
         end
         F3_W: begin
            ld_val       = {C_XLEN{ld_sh[31]}};
            ld_val[31:0] = ld_sh[31:0];
         end
         F3_BU: begin
            ld_val      = '0;
            ld_val[7:0] = ld_sh[7:0];
         end
         F3_HU: begin
            ld_val       = '0;
            ld_val[15:0] = ld_sh[15:0];
         end
         F3_WU: begin
            ld_val       = '0;
            ld_val[31:0] = ld_sh[31:0];
         end
         default: ld_val = ld_sh;
      endcase
   end

   // ------------------------------------------------------------ issue FSM
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= S_IDLE;
         store_q     <= 1'b0;
         funct3_q    <= '0;
         regd_q      <= '0;
         hpl_q       <= '0;
         addr_q      <= '0;
         wben_q      <= '0;
         wdata_q     <= '0;
         dreqvalid_q <= 1'b0;
         drspready_q <= 1'b0;
         reg_wr_q    <= 1'b0;
         reg_addr_q  <= '0;
         reg_data_q  <= '0;
         lerr_q      <= 1'b0;
         serr_q      <= 1'b0;
         err_addr_q  <= '0;
      end else if (clk_en_i) begin
         // Writeback and fault strobes are single-cycle pulses.
         reg_wr_q <= 1'b0;
         lerr_q   <= 1'b0;
         serr_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (!fifo_empty) begin
                  state_q     <= S_REQ;
                  dreqvalid_q <= 1'b1;
                  store_q     <= hd_store;
                  funct3_q    <= hd_f3;
                  regd_q      <= hd_rd;
                  hpl_q       <= hd_hpl;
                  addr_q      <= hd_addr;
                  wben_q      <= st_wben;
                  wdata_q     <= st_wdata;
               end
            end
            S_REQ: begin
               if (dreqready_i) begin
                  state_q     <= S_RSP;
                  dreqvalid_q <= 1'b0;
                  drspready_q <= 1'b1;
               end
            end
            S_RSP: begin
               if (drspvalid_i) begin
                  state_q     <= S_IDLE;
                  drspready_q <= 1'b0;
                  if (store_q) begin
                     if (drspwerr_i) begin
                        serr_q     <= 1'b1;
                        err_addr_q <= addr_q;
                     end
                  end else if (drsprerr_i) begin
                     lerr_q     <= 1'b1;
                     err_addr_q <= addr_q;
                  end else if (regd_q != 5'd0) begin
                     // x0 loads still perform the access but never write back.
                     reg_wr_q   <= 1'b1;
                     reg_addr_q <= regd_q;
                     reg_data_q <= ld_val;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign dreqvalid_o     = dreqvalid_q;
   assign dreqhpl_o       = hpl_q;
   assign dreqaddr_o      = addr_q;
   assign dreqwr_o        = store_q;
   assign dreqwben_o      = wben_q;
   assign dreqwdata_o     = wdata_q;
   assign drspready_o     = drspready_q;
   assign ids_reg_wr_o    = reg_wr_q;
   assign ids_reg_addr_o  = reg_addr_q;
   assign ids_reg_data_o  = reg_data_q;
   assign hvec_lerr_o     = lerr_q;
   assign hvec_serr_o     = serr_q;
   assign hvec_err_addr_o = err_addr_q;

endmodule

// File: tb/tb_lsq.sv
// Bench for lsq: an RV32 and an RV64 instance share stimulus; sel64 picks
// which one is enqueued to and observed through the m_* output muxes.
module tb_lsq;
   import lsq_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, clk_en, lq_wr, sq_wr, sel64;
   logic [2:0]  f3;
   logic [4:0]  rd;
   logic [1:0]  hpl;
   logic [63:0] addr, wd, rdat;
   logic        dreqready, drspvalid, rerr, werr;
   logic        lq32, sq32, lq64, sq64;

   assign lq32 = lq_wr & ~sel64;
   assign sq32 = sq_wr & ~sel64;
   assign lq64 = lq_wr & sel64;
   assign sq64 = sq_wr & sel64;

   logic        full32, dv32, dwr32, drdy32, rwr32, lerr32, serr32;
   logic [1:0]  dhpl32;
   logic [31:0] daddr32, dwd32, rdata32, eaddr32;
   logic [3:0]  dben32;
   logic [4:0]  raddr32;
   logic        full64, dv64, dwr64, drdy64, rwr64, lerr64, serr64;
   logic [1:0]  dhpl64;
   logic [63:0] daddr64, dwd64, rdata64, eaddr64;
   logic [7:0]  dben64;
   logic [4:0]  raddr64;

   lsq #(.C_XLEN_X(5), .C_DEPTH_X(2)) u32 (
      .clk_i(clk), .reset_i(reset), .clk_en_i(clk_en),
      .exs_lq_wr_i(lq32), .exs_sq_wr_i(sq32), .exs_funct3_i(f3),
      .exs_regd_addr_i(rd), .exs_regs2_data_i(wd[31:0]), .exs_addr_i(addr[31:0]),
      .exs_hpl_i(hpl), .exs_full_o(full32),
      .dreqready_i(dreqready), .dreqvalid_o(dv32), .dreqhpl_o(dhpl32),
      .dreqaddr_o(daddr32), .dreqwr_o(dwr32), .dreqwben_o(dben32), .dreqwdata_o(dwd32),
      .drspready_o(drdy32), .drspvalid_i(drspvalid), .drsprerr_i(rerr),
      .drspwerr_i(werr), .drspdata_i(rdat[31:0]),
      .ids_reg_wr_o(rwr32), .ids_reg_addr_o(raddr32), .ids_reg_data_o(rdata32),
      .hvec_lerr_o(lerr32), .hvec_serr_o(serr32), .hvec_err_addr_o(eaddr32)
   );

   lsq #(.C_XLEN_X(6), .C_DEPTH_X(2)) u64 (
      .clk_i(clk), .reset_i(reset), .clk_en_i(clk_en),
      .exs_lq_wr_i(lq64), .exs_sq_wr_i(sq64), .exs_funct3_i(f3),
      .exs_regd_addr_i(rd), .exs_regs2_data_i(wd), .exs_addr_i(addr),
      .exs_hpl_i(hpl), .exs_full_o(full64),
      .dreqready_i(dreqready), .dreqvalid_o(dv64), .dreqhpl_o(dhpl64),
      .dreqaddr_o(daddr64), .dreqwr_o(dwr64), .dreqwben_o(dben64), .dreqwdata_o(dwd64),
      .drspready_o(drdy64), .drspvalid_i(drspvalid), .drsprerr_i(rerr),
      .drspwerr_i(werr), .drspdata_i(rdat),
      .ids_reg_wr_o(rwr64), .ids_reg_addr_o(raddr64), .ids_reg_data_o(rdata64),
      .hvec_lerr_o(lerr64), .hvec_serr_o(serr64), .hvec_err_addr_o(eaddr64)
   );

   logic        m_full, m_dv, m_dwr, m_drdy, m_rwr, m_lerr, m_serr;
   logic [1:0]  m_hpl;
   logic [4:0]  m_raddr;
   logic [7:0]  m_dben;
   logic [63:0] m_daddr, m_dwd, m_rdata, m_eaddr;

   assign m_full  = sel64 ? full64 : full32;
   assign m_dv    = sel64 ? dv64   : dv32;
   assign m_dwr   = sel64 ? dwr64  : dwr32;
   assign m_drdy  = sel64 ? drdy64 : drdy32;
   assign m_rwr   = sel64 ? rwr64  : rwr32;
   assign m_lerr  = sel64 ? lerr64 : lerr32;
   assign m_serr  = sel64 ? serr64 : serr32;
   assign m_hpl   = sel64 ? dhpl64 : dhpl32;
   assign m_raddr = sel64 ? raddr64 : raddr32;
   assign m_dben  = sel64 ? dben64 : {4'd0, dben32};
   assign m_daddr = sel64 ? daddr64 : {32'd0, daddr32};
   assign m_dwd   = sel64 ? dwd64   : {32'd0, dwd32};
   assign m_rdata = sel64 ? rdata64 : {32'd0, rdata32};
   assign m_eaddr = sel64 ? eaddr64 : {32'd0, eaddr32};

   typedef struct {
      logic        rv64;
      logic        st;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [1:0]  hpl;
      logic [63:0] addr;
      logic [63:0] wd;
      logic [63:0] rdat;
      logic        rerr;
      logic        werr;
      logic [7:0]  e_ben;
      logic [63:0] e_wdata;
      logic        e_wr;
      logic [63:0] e_data;
   } vec_t;

   localparam int NV = 19;
   vec_t tbl[NV];
   int n_chk = 0;
   int n_err = 0;

   function automatic vec_t mk(input logic rv, input logic st, input logic [2:0] fn,
                               input logic [4:0] rdi, input logic [63:0] a,
                               input logic [63:0] w, input logic [63:0] r,
                               input logic re, input logic we, input logic [7:0] ben,
                               input logic [63:0] ewd, input logic ewr,
                               input logic [63:0] edat);
      vec_t v;
      v.rv64 = rv; v.st = st; v.f3 = fn; v.rd = rdi; v.hpl = 2'd0;
      v.addr = a; v.wd = w; v.rdat = r; v.rerr = re; v.werr = we;
      v.e_ben = ben; v.e_wdata = ewd; v.e_wr = ewr; v.e_data = edat;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input string nm);
      int k;
      k = 0;
      while (!m_dv && k < 30) begin
         step();
         k++;
      end
      chk({nm, " req_vld"}, 64'(m_dv), 64'd1);
   endtask

   // One complete operation: enqueue, check request, accept, respond, check pulse.
   task automatic do_op(input int i);
      vec_t  t;
      string nm;
      int    k;
      t  = tbl[i];
      nm = $sformatf("v%0d", i);
      sel64 = t.rv64; f3 = t.f3; rd = t.rd; hpl = t.hpl; addr = t.addr; wd = t.wd;
      lq_wr = ~t.st; sq_wr = t.st;
      step();
      lq_wr = 1'b0; sq_wr = 1'b0;
      chk({nm, " lat_n1"}, 64'(m_dv), 64'd0);
      step();
      k = 0;
      while (!m_dv && k < 30) begin
         step();
         k++;
      end
      chk({nm, " lat_n2"}, 64'(k), 64'd0);
      chk({nm, " dreqaddr"}, m_daddr, t.addr);
      chk({nm, " dreqwr"}, 64'(m_dwr), 64'(t.st));
      chk({nm, " wben"}, 64'(m_dben), 64'(t.e_ben));
      chk({nm, " hpl"}, 64'(m_hpl), 64'(t.hpl));
      if (t.st) chk({nm, " wdata"}, m_dwd, t.e_wdata);
      dreqready = 1'b1;
      step();
      dreqready = 1'b0;
      chk({nm, " rsp_rdy"}, 64'({m_drdy, m_dv}), 64'b10);
      drspvalid = 1'b1; rdat = t.rdat; rerr = t.rerr; werr = t.werr;
      step();
      drspvalid = 1'b0; rerr = 1'b0; werr = 1'b0;
      chk({nm, " reg_wr"}, 64'(m_rwr), 64'(t.e_wr));
      chk({nm, " lerr"}, 64'(m_lerr), 64'(t.rerr));
      chk({nm, " serr"}, 64'(m_serr), 64'(t.werr));
      if (t.e_wr) begin
         chk({nm, " reg_addr"}, 64'(m_raddr), 64'(t.rd));
         chk({nm, " reg_data"}, m_rdata, t.e_data);
      end
      if (t.rerr || t.werr) chk({nm, " err_addr"}, m_eaddr, t.addr);
      step();
      chk({nm, " pulse_end"}, 64'({m_rwr, m_lerr, m_serr}), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen;
      reset = 1'b1; clk_en = 1'b1; lq_wr = 1'b0; sq_wr = 1'b0; sel64 = 1'b0;
      f3 = '0; rd = '0; hpl = '0; addr = '0; wd = '0; rdat = '0;
      dreqready = 1'b0; drspvalid = 1'b0; rerr = 1'b0; werr = 1'b0;

      //             rv st f3     rd  addr    wdata          rdata                rerr werr ben  exp_wdata                   wr exp_data
      tbl[0]  = mk(0, 1, F3_W,  0,  'h100, 'hDEADBEEF, 0,                   0, 0, 'hF, 64'hDEADBEEF,           0, 0);
      tbl[1]  = mk(0, 0, F3_B,  5,  'h103, 0,          'h80FFFFFF,          0, 0, 0,   0,                      1, 64'hFFFFFF80);
      tbl[2]  = mk(0, 0, F3_BU, 5,  'h103, 0,          'h80FFFFFF,          0, 0, 0,   0,                      1, 64'h80);
      tbl[3]  = mk(0, 1, F3_H,  0,  'h102, 'h1234,     0,                   0, 0, 'hC, 64'h12341234,           0, 0);
      tbl[4]  = mk(0, 0, F3_H,  7,  'h2,   0,          'h80010000,          0, 0, 0,   0,                      1, 64'hFFFF8001);
      tbl[5]  = mk(0, 0, F3_HU, 7,  'h2,   0,          'h80010000,          0, 0, 0,   0,                      1, 64'h8001);
      tbl[6]  = mk(0, 0, F3_W,  31, 'h10,  0,          'h76543210,          0, 0, 0,   0,                      1, 64'h76543210);
      tbl[7]  = mk(0, 1, F3_B,  0,  'h1,   'h123456A5, 0,                   0, 0, 'h2, 64'hA5A5A5A5,           0, 0);
      tbl[8]  = mk(0, 0, F3_B,  0,  'h0,   0,          'h7F,                0, 0, 0,   0,                      0, 0);
      tbl[9]  = mk(0, 0, F3_W,  3,  'h200, 0,          'h55,                1, 0, 0,   0,                      0, 0);
      tbl[10] = mk(0, 1, F3_W,  0,  'h300, 'h1,        0,                   0, 1, 'hF, 64'h1,                  0, 0);
      tbl[11] = mk(0, 0, F3_B,  9,  'h101, 0,          'h7F00,              0, 0, 0,   0,                      1, 64'h7F);
      tbl[12] = mk(1, 0, F3_WU, 6,  'h4,   0,          64'hFFFFFFFF00000000, 0, 0, 0,  0,                      1, 64'h00000000FFFFFFFF);
      tbl[13] = mk(1, 0, F3_W,  6,  'h4,   0,          64'hFFFFFFFF00000000, 0, 0, 0,  0,                      1, 64'hFFFFFFFFFFFFFFFF);
      tbl[14] = mk(1, 1, F3_D,  0,  'h8,   64'h0123456789ABCDEF, 0,          0, 0, 'hFF, 64'h0123456789ABCDEF,  0, 0);
      tbl[15] = mk(1, 1, F3_W,  0,  'h4,   'hCAFEF00D, 0,                   0, 0, 'hF0, 64'hCAFEF00DCAFEF00D,  0, 0);
      tbl[16] = mk(1, 0, F3_D,  1,  'h0,   0,          64'h8000000000000001, 0, 0, 0,  0,                      1, 64'h8000000000000001);
      tbl[17] = mk(1, 0, F3_H,  2,  'h6,   0,          64'h8765000000000000, 0, 0, 0,  0,                      1, 64'hFFFFFFFFFFFF8765);
      tbl[18] = mk(1, 1, F3_B,  0,  'h7,   'hAB,       0,                   0, 0, 'h80, 64'hABABABABABABABAB,  0, 0);
      for (int i = 0; i < NV; i++) tbl[i].hpl = 2'(i);

      repeat (3) step();
      reset = 1'b0;

      // Reset state of both instances.
      for (int s = 0; s < 2; s++) begin
         sel64 = s[0];
         #1;
         chk($sformatf("rst%0d ctl", s), 64'({m_full, m_dv, m_drdy, m_rwr, m_lerr, m_serr}), 64'd0);
         chk($sformatf("rst%0d dreqaddr", s), m_daddr, 64'd0);
         chk($sformatf("rst%0d wben_hpl_wr", s), 64'({m_dben, m_hpl, m_dwr}), 64'd0);
         chk($sformatf("rst%0d wdata", s), m_dwd, 64'd0);
         chk($sformatf("rst%0d reg_addr", s), 64'(m_raddr), 64'd0);
         chk($sformatf("rst%0d reg_data", s), m_rdata, 64'd0);
         chk($sformatf("rst%0d err_addr", s), m_eaddr, 64'd0);
      end

      for (int i = 0; i < NV; i++) do_op(i);

      // Fill: first store sits in the issue registers, four more fill the queue.
      sel64 = 1'b0; dreqready = 1'b0; f3 = F3_W; hpl = 2'd0;
      sq_wr = 1'b1;
      for (int k = 0; k < 5; k++) begin
         addr = 64'('h10 * (k + 1));
         wd   = 64'(k);
         step();
      end
      sq_wr = 1'b0;
      chk("fill full", 64'(m_full), 64'd1);
      sq_wr = 1'b1; addr = 'h60;
      step();
      sq_wr = 1'b0;
      chk("fill full_hold", 64'(m_full), 64'd1);
      for (int k = 0; k < 5; k++) begin
         wait_req($sformatf("fill%0d", k));
         chk($sformatf("fill%0d addr", k), m_daddr, 64'('h10 * (k + 1)));
         dreqready = 1'b1;
         step();
         dreqready = 1'b0;
         drspvalid = 1'b1;
         step();
         drspvalid = 1'b0;
      end
      seen = 1'b0;
      repeat (6) begin
         step();
         seen |= m_dv;
      end
      chk("fill dropped_6th", 64'(seen), 64'd0);
      chk("fill empty", 64'(m_full), 64'd0);

      // Clock-enable freeze: request holds, pulse holds, enqueue ignored.
      f3 = F3_W; rd = 5'd4; addr = 'h20;
      lq_wr = 1'b1;
      step();
      lq_wr = 1'b0;
      wait_req("frz");
      clk_en = 1'b0; dreqready = 1'b1;
      step();
      chk("frz req_hold", 64'({m_dv, m_drdy}), 64'b10);
      clk_en = 1'b1;
      step();
      dreqready = 1'b0;
      drspvalid = 1'b1; rdat = 'h11;
      step();
      drspvalid = 1'b0;
      chk("frz wr", 64'(m_rwr), 64'd1);
      clk_en = 1'b0; lq_wr = 1'b1; addr = 'h40;
      step();
      step();
      lq_wr = 1'b0;
      chk("frz wr_hold", 64'(m_rwr), 64'd1);
      chk("frz data", m_rdata, 64'h11);
      clk_en = 1'b1;
      step();
      chk("frz wr_clear", 64'(m_rwr), 64'd0);
      seen = 1'b0;
      repeat (5) begin
         step();
         seen |= m_dv;
      end
      chk("frz no_enq", 64'(seen), 64'd0);

      // Reset mid-transaction abandons the request and clears the queue.
      f3 = F3_W; addr = 'h80; wd = 'h5;
      sq_wr = 1'b1;
      step();
      addr = 'h84;
      step();
      sq_wr = 1'b0;
      wait_req("mrst");
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mrst ctl", 64'({m_dv, m_drdy, m_full}), 64'd0);
      seen = 1'b0;
      repeat (5) begin
         step();
         seen |= m_dv;
      end
      chk("mrst no_req", 64'(seen), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
